// File: rtl/if_id_hazard_ctrl.sv
// PC / IF-ID / ID-EX sequencing for load-use, branch redirect, IMEM wait and halt.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush event counters.
module if_id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
`endif
  output logic [1:0]       state_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             pc_w_c, ifw_c, flush_c, bubble_c;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_w_c   = 1'b0;
    ifw_c    = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b1;
    if (branch_taken) begin
      // Redirect wins in every state; the branch cycle itself is the first flush cycle.
      pc_w_c  = 1'b1;
      flush_c = 1'b1;
      cnt_d   = CNT_RELOAD;
      state_d = (CNT_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // Flush must complete before a halt is honoured, else a wrong-path op survives.
          flush_c = 1'b1;
          pc_w_c  = imem_ready;
          if (imem_ready) begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (!halt_req) state_d = ST_RUN;
        end
        default: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (!imem_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RUN;
            if (!lu) begin
              pc_w_c   = 1'b1;
              ifw_c    = 1'b1;
              bubble_c = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write     = reset_n & pc_w_c;
  assign if_id_write  = reset_n & ifw_c;
  assign if_id_flush  = ~reset_n | flush_c;
  assign id_ex_bubble = ~reset_n | bubble_c;
  assign state_o      = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && !if_id_flush && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
